// File: rtl/hwpe_stream_tcdm_writer_pkg.sv
// Shared types for the TCDM stream writer: FSM state encoding and
// controller-facing control/flag bundles.
package hwpe_stream_tcdm_writer_pkg;

  localparam int unsigned TCDM_WRITER_DATA_WIDTH = 32;
  localparam int unsigned TCDM_WRITER_ADDR_WIDTH = 32;
  localparam int unsigned TCDM_WRITER_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    TW_IDLE = 2'd0,
    TW_RUN  = 2'd1,
    TW_DONE = 2'd2
  } tcdm_writer_state_t;

  typedef struct packed {
    logic                              start;
    logic [TCDM_WRITER_ADDR_WIDTH-1:0] base_addr;
    logic [TCDM_WRITER_ADDR_WIDTH-1:0] stride;
    logic [TCDM_WRITER_CNT_WIDTH-1:0]  length;
  } ctrl_tcdm_writer_t;

  typedef struct packed {
    logic                             busy;
    logic                             done;
    logic [TCDM_WRITER_CNT_WIDTH-1:0] beat_cnt;
  } flags_tcdm_writer_t;

endpackage

// File: rtl/hwpe_stream_tcdm_writer_if.sv
// Byte-strobed valid/ready word stream as produced by the sink realigner.
interface hwpe_stream_tcdm_writer_if
  import hwpe_stream_tcdm_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = TCDM_WRITER_DATA_WIDTH
);

  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport master (output valid, data, strb, input  ready);
  modport slave  (input  valid, data, strb, output ready);
  modport source (output valid, data, strb, input  ready);
  modport sink   (input  valid, data, strb, output ready);

endinterface

// File: rtl/hwpe_stream_addressgen_simple.sv
// Strided word-address generator with beat counter and terminal-count flag.
module hwpe_stream_addressgen_simple
  import hwpe_stream_tcdm_writer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = TCDM_WRITER_ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH  = TCDM_WRITER_CNT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic                  advance_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  input  logic [CNT_WIDTH-1:0]  length_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [CNT_WIDTH-1:0]  beat_cnt_o,
  output logic                  last_o
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  always_comb begin
    addr_d   = addr_q;
    stride_d = stride_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      addr_d   = '0;
      stride_d = '0;
      len_d    = '0;
      cnt_d    = '0;
    end else if (load_i) begin
      addr_d   = base_addr_i;
      stride_d = stride_i;
      len_d    = length_i;
      cnt_d    = '0;
    end else if (advance_i) begin
      // Address wraps modulo 2^ADDR_WIDTH by plain truncation.
      addr_d = addr_q + stride_q;
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
    end else begin
      addr_q   <= addr_d;
      stride_q <= stride_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
    end
  end

  assign addr_o     = addr_q;
  assign beat_cnt_o = cnt_q;
  // High while the beat being presented is the final one of the transfer.
  assign last_o     = (CNT_WIDTH'(cnt_q + 1'b1) == len_q);

endmodule

// File: rtl/hwpe_stream_tcdm_writer.sv
// Stream-to-TCDM write master: one store per strobed beat at a strided
// address, with zero-latency pass-through handshake and busy/done flags.
module hwpe_stream_tcdm_writer
  import hwpe_stream_tcdm_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = TCDM_WRITER_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = TCDM_WRITER_ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH  = TCDM_WRITER_CNT_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [ADDR_WIDTH-1:0]   stride_i,
  input  logic [CNT_WIDTH-1:0]    length_i,
  hwpe_stream_tcdm_writer_if.sink stream_i,
  output logic                    tcdm_req_o,
  input  logic                    tcdm_gnt_i,
  output logic [ADDR_WIDTH-1:0]   tcdm_add_o,
  output logic                    tcdm_wen_o,
  output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
  output logic [DATA_WIDTH-1:0]   tcdm_data_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [CNT_WIDTH-1:0]    beat_cnt_o
);

  tcdm_writer_state_t state_q, state_d;

  logic load;
  logic advance;
  logic last;
  logic ready;
  logic req;
  logic strb_nz;

  assign strb_nz = |stream_i.strb;

  hwpe_stream_addressgen_simple #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) i_addressgen (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .load_i      (load),
    .advance_i   (advance),
    .base_addr_i (base_addr_i),
    .stride_i    (stride_i),
    .length_i    (length_i),
    .addr_o      (tcdm_add_o),
    .beat_cnt_o  (beat_cnt_o),
    .last_o      (last)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    req     = 1'b0;
    ready   = 1'b0;
    unique case (state_q)
      TW_IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          state_d = (length_i == '0) ? TW_DONE : TW_RUN;
        end
      end
      TW_RUN: begin
        // Zero-strobe beats are swallowed without touching the memory.
        req     = stream_i.valid & strb_nz;
        ready   = strb_nz ? tcdm_gnt_i : 1'b1;
        advance = stream_i.valid & ready;
        if (advance && last) state_d = TW_DONE;
      end
      TW_DONE: state_d = TW_IDLE;
      default: state_d = TW_IDLE;
    endcase
    if (clear_i) state_d = TW_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= TW_IDLE;
    else         state_q <= state_d;
  end

  assign stream_i.ready = ready;
  assign tcdm_req_o     = req;
  assign tcdm_wen_o     = 1'b0;
  assign tcdm_be_o      = stream_i.strb;
  assign tcdm_data_o    = stream_i.data;
  assign busy_o         = (state_q == TW_RUN);
  assign done_o         = (state_q == TW_DONE);

endmodule

// File: tb/tb_hwpe_stream_tcdm_writer.sv
// Randomized scoreboard bench for the stream-to-TCDM writer.
module tb_hwpe_stream_tcdm_writer;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] stride = '0;
  logic [15:0] length = '0;
  logic        tcdm_req;
  logic        tcdm_gnt = 1'b0;
  logic [31:0] tcdm_add;
  logic        tcdm_wen;
  logic [3:0]  tcdm_be;
  logic [31:0] tcdm_data;
  logic        busy;
  logic        done;
  logic [15:0] beat_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_seen = 0;
  int stall_pct = 0;
  wr_t exp_q[$];
  logic [7:0] gold[logic [31:0]];
  logic [7:0] obs[logic [31:0]];

  hwpe_stream_tcdm_writer_if #(.DATA_WIDTH(32)) stream ();

  hwpe_stream_tcdm_writer dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .start_i     (start),
    .base_addr_i (base_addr),
    .stride_i    (stride),
    .length_i    (length),
    .stream_i    (stream),
    .tcdm_req_o  (tcdm_req),
    .tcdm_gnt_i  (tcdm_gnt),
    .tcdm_add_o  (tcdm_add),
    .tcdm_wen_o  (tcdm_wen),
    .tcdm_be_o   (tcdm_be),
    .tcdm_data_o (tcdm_data),
    .busy_o      (busy),
    .done_o      (done),
    .beat_cnt_o  (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Grant source: stalls a configurable percentage of cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tcdm_gnt = ($urandom_range(0, 99) >= stall_pct);
    end
  end

  // Monitor: pops the scoreboard on every granted request and checks hold-stability.
  initial begin
    logic pend;
    wr_t  pend_w;
    wr_t  w;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (done) done_seen++;
        if (pend)
          check("stall_hold", {31'd0, tcdm_req && tcdm_add == pend_w.addr &&
                tcdm_data == pend_w.data && tcdm_be == pend_w.be}, 1);
        if (tcdm_req && tcdm_gnt) begin
          if (exp_q.size() == 0) begin
            check("req_unexpected", exp_q.size(), 1);
          end else begin
            w = exp_q.pop_front();
            $display("write addr=%08h data=%08h be=%h", tcdm_add, tcdm_data, tcdm_be);
            check("tcdm_add", tcdm_add, w.addr);
            check("tcdm_data", tcdm_data, w.data);
            check("tcdm_be", tcdm_be, w.be);
            check("tcdm_wen", tcdm_wen, 0);
            for (int k = 0; k < 4; k++)
              if (tcdm_be[k]) obs[tcdm_add + 32'(k)] = tcdm_data[8*k +: 8];
          end
        end
        pend        = tcdm_req && !tcdm_gnt;
        pend_w.addr = tcdm_add;
        pend_w.data = tcdm_data;
        pend_w.be   = tcdm_be;
      end
    end
  end

  function automatic logic [3:0] pick_strb(input int mode, input int i, input int len);
    int r;
    case (mode)
      1: begin
        if (i == 0) return 4'hC;
        else if (i == len - 1) return 4'h3;
        else return 4'hF;
      end
      2: return (i == 3) ? 4'h0 : 4'hF;
      3: begin
        r = $urandom_range(0, 4);
        return (r == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      default: return 4'hF;
    endcase
  endfunction

  // Drives one transfer; positions are always #1 after a rising edge.
  task automatic do_transfer(input logic [31:0] b, input logic [31:0] s, input int len,
                             input int mode, input int stall, input int clear_after,
                             input bit probe_start);
    int          done_before;
    int          n;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  st;
    logic [31:0] addrs[$];
    logic [31:0] ow;
    logic [31:0] gw;
    stall_pct   = stall;
    done_before = done_seen;
    start       = 1'b1;
    base_addr   = b;
    stride      = s;
    length      = 16'(len);
    @(posedge clk); #1;
    start = 1'b0;
    check("beat_cnt_at_start", beat_cnt, 0);
    if (len == 0) begin
      check("done_len0", done, 1);
      check("busy_len0", busy, 0);
      @(posedge clk); #1;
      check("done_len0_pulse", done, 0);
      check("done_len0_count", done_seen - done_before, 1);
      check("queue_len0", exp_q.size(), 0);
      return;
    end
    check("busy_run", busy, 1);
    for (int i = 0; i < len; i++) begin
      if (i == clear_after) begin
        stream.valid = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("busy_after_clear", busy, 0);
        check("beat_cnt_after_clear", beat_cnt, 0);
        @(posedge clk); #1;
        check("no_done_after_clear", done_seen - done_before, 0);
        check("queue_after_clear", exp_q.size(), 0);
        return;
      end
      st = pick_strb(mode, i, len);
      d  = $urandom;
      a  = b + 32'(i) * s;
      addrs.push_back(a);
      for (int k = 0; k < 4; k++) begin
        if (!gold.exists(a + 32'(k))) begin
          gold[a + 32'(k)] = 8'hA5;
          obs[a + 32'(k)]  = 8'hA5;
        end
        if (st[k]) gold[a + 32'(k)] = d[8*k +: 8];
      end
      if (st != 4'h0) exp_q.push_back('{addr: a, data: d, be: st});
      if (probe_start && i == 2) begin
        start     = 1'b1;
        base_addr = 32'hDEAD_0000;
        length    = 16'd3;
      end else begin
        start = 1'b0;
      end
      stream.valid = 1'b1;
      stream.data  = d;
      stream.strb  = st;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!stream.ready && n < 200);
      if (!stream.ready) begin
        check("beat_accept_timeout", stream.ready, 1);
        stream.valid = 1'b0;
        start = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    start        = 1'b0;
    stream.valid = 1'b0;
    stream.strb  = 4'h0;
    check("done_pulse", done, 1);
    check("busy_in_done", busy, 0);
    check("beat_cnt_final", beat_cnt, 64'(len));
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("beat_cnt_hold", beat_cnt, 64'(len));
    check("done_count", done_seen - done_before, 1);
    check("queue_drained", exp_q.size(), 0);
    foreach (addrs[j]) begin
      for (int k = 0; k < 4; k++) begin
        ow[8*k +: 8] = obs[addrs[j] + 32'(k)];
        gw[8*k +: 8] = gold[addrs[j] + 32'(k)];
      end
      check("mem_word", ow, gw);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stream.valid = 1'b0;
    stream.data  = '0;
    stream.strb  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", tcdm_req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", stream.ready, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_transfer(32'h1000, 32'd4, 8, 0, 0, -1, 1'b1);
    do_transfer(32'h1000, 32'd4, 8, 0, 30, -1, 1'b0);
    do_transfer(32'h3000, 32'd4, 5, 1, 30, -1, 1'b0);
    do_transfer(32'h4000, 32'd8, 6, 2, 0, -1, 1'b0);
    do_transfer(32'h5000, 32'd4, 0, 0, 0, -1, 1'b0);
    do_transfer(32'h1000, 32'd4, 8, 0, 0, 3, 1'b0);
    do_transfer(32'h2000, 32'd4, 8, 0, 20, -1, 1'b0);
    do_transfer(32'hFFFF_FFF8, 32'd4, 4, 0, 0, -1, 1'b0);
    for (int t = 0; t < 6; t++)
      do_transfer(32'h8000 + 32'($urandom_range(0, 255)) * 4, 32'($urandom_range(1, 8)) * 4,
                  $urandom_range(1, 12), 3, 30, -1, 1'b0);

    // Asynchronous reset while a request is waiting for its grant.
    stall_pct = 100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = 32'h6000;
    stride    = 32'd4;
    length    = 16'd8;
    @(posedge clk); #1;
    start        = 1'b0;
    stream.valid = 1'b1;
    stream.data  = $urandom;
    stream.strb  = 4'hF;
    @(negedge clk);
    check("req_stalled", tcdm_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req", tcdm_req, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_ready", stream.ready, 0);
    check("async_rst_beat_cnt", beat_cnt, 0);
    stream.valid = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    stall_pct = 0;
    @(posedge clk); #1;
    do_transfer(32'h7000, 32'd4, 3, 0, 0, -1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hwpe_stream_tcdm_writer.md
Name: hwpe_stream_tcdm_writer

Overview:
- Stream-to-memory write master placed directly downstream of hwpe_stream_sink_realign.
- Consumes the realigned, byte-strobed word stream and issues one TCDM store per accepted beat.
- Generates a strided word address sequence and counts beats against a programmed length.
- Reports busy and a single-cycle done pulse to the engine controller.

Parameters:
- DATA_WIDTH, 32, stream/TCDM data width in bits; multiple of 8.
- ADDR_WIDTH, 32, TCDM byte-address width.
- CNT_WIDTH, 16, width of the length and beat counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous soft clear.
- start_i  in  1  launch a transfer; sampled only in IDLE.
- base_addr_i  in  ADDR_WIDTH  byte address of the first word.
- stride_i  in  ADDR_WIDTH  byte increment between successive words.
- length_i  in  CNT_WIDTH  number of stream beats to consume.
- stream_i  in/out  hwpe_stream_intf_stream.sink (DATA_WIDTH)  realigned data, strb, valid/ready.
- tcdm_req_o  out  1  store request.
- tcdm_gnt_i  in  1  grant.
- tcdm_add_o  out  ADDR_WIDTH  store address.
- tcdm_wen_o  out  1  constant 0 (write).
- tcdm_be_o  out  DATA_WIDTH/8  byte enables = stream strb.
- tcdm_data_o  out  DATA_WIDTH  store data.
- busy_o  out  1  high in RUN.
- done_o  out  1  one-cycle pulse on completion.
- beat_cnt_o  out  CNT_WIDTH  beats consumed in the current transfer.

Behaviour:
- Reset values: state IDLE; addr, length and beat counters 0; busy_o 0; done_o 0; tcdm_req_o 0; stream ready 0.
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - start_i latches base_addr_i into the address register, stride_i and length_i, clears beat_cnt, and moves to RUN.
  - If length_i == 0, the FSM moves to DONE instead.
- RUN, combinational handshake (zero latency, no buffering):
  - tcdm_req_o = stream.valid & (strb != 0).
  - stream.ready = (strb != 0) ? tcdm_gnt_i : 1.
  - tcdm_add_o = address register; tcdm_data_o and tcdm_be_o pass through from the stream.
- Beat accepted (valid & ready):
  - Address advances by stride, modulo 2^ADDR_WIDTH; wrap is silent.
  - beat_cnt increments.
  - Zero-strobe beat: consumed without a TCDM request; address still advances.
- On acceptance of beat number length, the FSM moves to DONE the next cycle.
  - No further beats are accepted; ready is 0 outside RUN.
- DONE: done_o = 1 for exactly one cycle, then IDLE. beat_cnt_o holds its final value until the next start.
- start_i while in RUN or DONE is ignored; parameters are not re-latched.
- clear_i (any state) on the next edge:
  - Returns the FSM to IDLE and zeroes the counters.
  - No done pulse; takes priority over a concurrent beat acceptance.
- Reset asserted mid-transfer: all state clears asynchronously; the TCDM request drops immediately.
- tcdm_req_o must stay asserted with stable addr/data/be until granted, because the stream holds valid and data stable.
- The block registers no stream data.
- busy_o = (state == RUN).

Decomposition:
- hwpe_stream_package gains a typedef ctrl_tcdm_writer_t {start, base_addr, stride, length} and flags_tcdm_writer_t {busy, done, beat_cnt}, plus a tcdm_writer_state_t enum.
- One natural sub-module: hwpe_stream_addressgen_simple, containing the address register, stride adder and beat counter with terminal-count flag.
- The top holds the FSM and handshake glue.

Test Plan:
- Basic transfer:
  - Stimulus: base=0x1000, stride=4, length=8; full strobes; always-grant.
  - Required: 8 requests at 0x1000..0x101C with be=0xF; done_o pulses once, 1 cycle after the 8th grant; beat_cnt_o=8.
- Grant stalls:
  - Stimulus: same setup with 30% random gnt=0.
  - Required: req/addr/data stable while ungranted; no beat lost or duplicated; memory model matches the stream golden vector.
- Partial strobes from the realigner:
  - Stimulus: first beat strb=0xC, last beat strb=0x3, length=5.
  - Required: tcdm_be_o equals strb on each request; the bytes outside the strobes in the memory model are unchanged.
- Zero-strobe beat and length 0:
  - Stimulus A: beat 3 has strb=0.
  - Required A: no request for beat 3; the address of beat 4 is base+4*stride.
  - Stimulus B: length=0.
  - Required B: done_o 1 cycle after start_i; no request issued.
- Clear mid-transfer:
  - Stimulus: clear_i pulsed after beat 3 of 8, then restart with base=0x2000.
  - Required: no done pulse from the cleared transfer; the restarted transfer begins at 0x2000; beat_cnt_o restarts at 0.
- Address wrap and async reset:
  - Stimulus A: base=0xFFFFFFF8, stride=4, length=4.
  - Required A: addresses FFFFFFF8, FFFFFFFC, 0, 4.
  - Stimulus B: rst_ni low mid-RUN.
  - Required B: req, busy and done drop to 0 without waiting for a clock edge.
